// File: rtl/lector_teclado.sv
// rtl/lector_teclado.sv - 4x4 keypad reader: column sync, row realignment, per-scan debounce, one-shot key strobe
module lector_teclado #(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fila,
  input  logic [WIDTH-1:0] columna,
  output logic [3:0]       tecla,
  output logic             tecla_valida,
  output logic             tecla_presionada
);

  localparam logic [3:0]       N_SCANS = 4'(DEBOUNCE_SCANS);
  localparam logic [WIDTH-1:0] ROW0    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_NONE, S_SINGLE, S_MULTI} sum_t;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  logic [WIDTH-1:0] col_s1, col_s2;
  logic [WIDTH-1:0] fila_d1, fila_d2;
  sum_t             sum_kind, smp_kind, base_kind, nxt_kind;
  logic [3:0]       sum_key, smp_key, nxt_key;
  logic             started;
  state_t           state;
  logic [3:0]       cand;
  logic [3:0]       cnt;
  logic [3:0]       rel;
  logic             fila_ok, boundary;

  function automatic logic [1:0] idx(input logic [WIDTH-1:0] v);
    idx = 2'd0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = i[1:0];
  endfunction

  assign fila_ok  = $onehot(fila_d2);
  assign boundary = (fila_d2 == ROW0);

  // Fold the current aligned sample into the running scan summary; a boundary starts a fresh summary.
  always_comb begin
    smp_kind = S_NONE;
    smp_key  = {idx(fila_d2), idx(col_s2)};
    if (col_s2 != '0)
      smp_kind = $onehot(col_s2) ? S_SINGLE : S_MULTI;
    base_kind = boundary ? S_NONE : sum_kind;
    nxt_kind  = base_kind;
    nxt_key   = sum_key;
    case (smp_kind)
      S_MULTI: nxt_kind = S_MULTI;
      S_SINGLE: begin
        if (base_kind == S_NONE) begin
          nxt_kind = S_SINGLE;
          nxt_key  = smp_key;
        end else if (base_kind == S_SINGLE && sum_key != smp_key) begin
          nxt_kind = S_MULTI;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1           <= '0;
      col_s2           <= '0;
      fila_d1          <= '0;
      fila_d2          <= '0;
      sum_kind         <= S_NONE;
      sum_key          <= 4'd0;
      started          <= 1'b0;
      state            <= IDLE;
      cand             <= 4'd0;
      cnt              <= 4'd0;
      rel              <= 4'd0;
      tecla            <= 4'd0;
      tecla_valida     <= 1'b0;
      tecla_presionada <= 1'b0;
    end else begin
      col_s1       <= columna;
      col_s2       <= col_s1;
      fila_d1      <= fila;
      fila_d2      <= fila_d1;
      tecla_valida <= 1'b0;

      if (fila_ok) begin
        sum_kind <= nxt_kind;
        sum_key  <= nxt_key;
      end

      // The very first boundary closes no complete scan, so it only arms evaluation.
      if (boundary) begin
        started <= 1'b1;
        if (started) begin
          case (state)
            IDLE: begin
              if (sum_kind == S_SINGLE) begin
                if (N_SCANS == 4'd1) begin
                  tecla            <= sum_key;
                  tecla_valida     <= 1'b1;
                  tecla_presionada <= 1'b1;
                  rel              <= 4'd0;
                  state            <= PRESSED;
                end else begin
                  cand  <= sum_key;
                  cnt   <= 4'd1;
                  state <= DEBOUNCE;
                end
              end
            end
            DEBOUNCE: begin
              if (sum_kind == S_SINGLE && sum_key == cand) begin
                if (cnt + 4'd1 >= N_SCANS) begin
                  tecla            <= sum_key;
                  tecla_valida     <= 1'b1;
                  tecla_presionada <= 1'b1;
                  rel              <= 4'd0;
                  cnt              <= 4'd0;
                  state            <= PRESSED;
                end else begin
                  cnt <= cnt + 4'd1;
                end
              end else if (sum_kind == S_SINGLE) begin
                cand <= sum_key;
                cnt  <= 4'd1;
              end else begin
                cnt   <= 4'd0;
                state <= IDLE;
              end
            end
            PRESSED: begin
              if (sum_kind != S_NONE) begin
                rel <= 4'd0;
              end else if (rel + 4'd1 >= N_SCANS) begin
                rel              <= 4'd0;
                tecla_presionada <= 1'b0;
                state            <= IDLE;
              end else begin
                rel <= rel + 4'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lector_teclado.sv
// tb/tb_lector_teclado.sv - table-driven bench for lector_teclado with a ring-counter and keypad model
`timescale 1ns/1ps
module tb_lector_teclado;

  logic       clk;
  logic       rst;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_presionada;

  lector_teclado #(.WIDTH(4), .DEBOUNCE_SCANS(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .fila             (fila),
    .columna          (columna),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .tecla_presionada (tecla_presionada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          nscans;
    int          pulse_at;
    int          exp_pulses;
    logic [3:0]  exp_tecla;
    logic        exp_pres;
  } vec_t;

  vec_t tbl [17];
  int   total  = 0;
  int   passed = 0;
  int   pulses = 0;
  int   dbl    = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tecla_valida) pulses++;
    if (tecla_valida && prev_v) dbl++;
    prev_v = tecla_valida;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full ring rotation; each row sees the columns of the pressed keys in that row.
  task automatic do_scan(input logic [15:0] mask);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      fila    = 4'(1 << r);
      columna = mask[r*4 +: 4];
    end
    #1;
  endtask

  task automatic run_row(input int i);
    for (int s = 1; s <= tbl[i].nscans; s++) begin
      do_scan(tbl[i].mask);
      chk($sformatf("row%0d scan%0d valid", i, s), 32'(tecla_valida), 32'(s == tbl[i].pulse_at));
      if (s == tbl[i].pulse_at)
        chk($sformatf("row%0d pulse tecla", i), 32'(tecla), 32'(tbl[i].exp_tecla));
    end
    chk($sformatf("row%0d pulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
    chk($sformatf("row%0d tecla", i), 32'(tecla), 32'(tbl[i].exp_tecla));
    chk($sformatf("row%0d presionada", i), 32'(tecla_presionada), 32'(tbl[i].exp_pres));
  endtask

  initial begin
    tbl[0]  = '{16'h0000, 20, 0, 0, 4'h0, 1'b0};
    tbl[1]  = '{16'h0040,  6, 4, 1, 4'h6, 1'b1};
    tbl[2]  = '{16'h0000,  3, 0, 1, 4'h6, 1'b1};
    tbl[3]  = '{16'h0000,  2, 0, 1, 4'h6, 1'b0};
    tbl[4]  = '{16'h8000,  2, 0, 1, 4'h6, 1'b0};
    tbl[5]  = '{16'h0000,  1, 0, 1, 4'h6, 1'b0};
    tbl[6]  = '{16'h8000,  3, 0, 1, 4'h6, 1'b0};
    tbl[7]  = '{16'h0000,  4, 1, 2, 4'hF, 1'b0};
    tbl[8]  = '{16'h0004,  2, 0, 2, 4'hF, 1'b0};
    tbl[9]  = '{16'h0200,  3, 0, 2, 4'hF, 1'b0};
    tbl[10] = '{16'h0000,  4, 1, 3, 4'h9, 1'b0};
    tbl[11] = '{16'h0030,  4, 0, 3, 4'h9, 1'b0};
    tbl[12] = '{16'h0021,  5, 0, 3, 4'h9, 1'b0};
    tbl[13] = '{16'h0020, 10, 4, 4, 4'h5, 1'b1};
    tbl[14] = '{16'h0000,  4, 0, 4, 4'h5, 1'b0};
    tbl[15] = '{16'h0008,  4, 4, 5, 4'h3, 1'b1};
    tbl[16] = '{16'h0008,  4, 4, 6, 4'h3, 1'b1};

    rst     = 1'b0;
    fila    = 4'd0;
    columna = 4'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      fila    = 4'($urandom);
      columna = 4'($urandom);
      #1;
      chk($sformatf("reset outputs c%0d", c), {26'd0, tecla, tecla_valida, tecla_presionada}, 32'd0);
    end
    @(negedge clk);
    fila    = 4'd0;
    columna = 4'd0;
    rst     = 1'b1;

    for (int i = 0; i <= 15; i++) run_row(i);

    // Reset asserted mid-press with the key still held and the ring still turning.
    @(negedge clk);
    fila    = 4'b0001;
    columna = 4'b1000;
    rst     = 1'b0;
    #1;
    chk("midreset tecla", 32'(tecla), 32'd0);
    chk("midreset valid", 32'(tecla_valida), 32'd0);
    chk("midreset presionada", 32'(tecla_presionada), 32'd0);
    @(negedge clk);
    fila    = 4'b0010;
    columna = 4'b0000;
    @(negedge clk);
    fila    = 4'b0100;
    @(negedge clk);
    fila    = 4'b1000;
    rst     = 1'b1;
    #1;
    chk("postreset presionada", 32'(tecla_presionada), 32'd0);

    run_row(16);

    do_scan(16'h0000);
    chk("no double-wide pulse", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
